// File: rtl/spi_reg_ctrl.sv
// ---------------------------------------------------------------------------
// spi_reg_ctrl
//
// Command controller behind an SPI slave byte interface. A chip-select framed
// byte stream is decoded into register-bank accesses:
//   byte 0       : command, bit 7 = read (1) / write (0), bits [ADDR_W-1:0] = address
//   bytes 1..n   : write data (write burst) or dummy bytes (read burst)
// The address auto-increments (mod 2^ADDR_W) after every data byte. For reads
// the first byte is prefetched straight after the command byte, and each
// following byte is prefetched when the master has clocked out the previous one.
//
// The SPI-domain cs and rx_valid are synchronized into clk here. rx_data is
// only sampled once the synchronized rx_valid edge is seen, when it is stable.
//
// Ports:
//   clk, rst             system clock, asynchronous active-high reset
//   cs                   SPI chip select (active low, asynchronous)
//   rx_data, rx_valid    received byte and its flag from the SPI slave
//   tx_data, tx_start    byte to return to the master and its 1-cycle load pulse
//   reg_addr, reg_wdata  register bank address / write data
//   reg_we, reg_re       1-cycle write / read strobes
//   reg_rdata            register read data, valid the cycle after reg_re
//   busy                 frame active (registered, inverted synchronized cs)
//   err                  sticky out-of-range flag, cleared when a new frame starts
// ---------------------------------------------------------------------------
module spi_reg_ctrl #(
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WR,
        S_RD_REQ,
        S_RD_LOAD,
        S_RD_WAIT
    } state_t;

    // One extra bit so DEPTH == 2^ADDR_W is representable in the compare.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_LIM;
    endfunction

    // ------------------------------------------------------------------
    // Synchronizers and strobe generation
    // ------------------------------------------------------------------
    logic [1:0]        cs_sync;
    logic              cs_s;
    logic [1:0]        rxv_sync;
    logic              rxv_prev;
    logic              rx_stb;
    logic [7:0]        rx_byte;
    logic [1:0]        sync_ready;
    logic              armed;

    assign cs_s = cs_sync[1];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, exactly like hardware.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync    <= 2'b11;
            rxv_sync   <= 2'b00;
            rxv_prev   <= 1'b0;
            rx_stb     <= 1'b0;
            rx_byte    <= 8'h00;
            sync_ready <= 2'b00;
            armed      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            cs_sync    <= {cs_sync[0], cs};
            rxv_sync   <= {rxv_sync[0], rx_valid};
            rxv_prev   <= rxv_sync[1];
            rx_stb     <= rxv_sync[1] & ~rxv_prev;
            if (rxv_sync[1] && !rxv_prev) begin
                rx_byte <= rx_data;
            end
            // The cs synchronizer resets to "deselected"; only trust cs_s once
            // real cs has flushed through, so a frame already running at reset
            // release is ignored until cs has been seen high.
            sync_ready <= {sync_ready[0], 1'b1};
            if (sync_ready[1] && cs_s) begin
                armed <= 1'b1;
            end
            busy <= ~cs_s;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    // NOTE: every variable written in an always_comb gets a default first,
    // otherwise paths that skip an assignment infer a latch.
    always_comb begin
        state_nxt = state;
        if (cs_s) begin
            // Deselect wins over everything, including a coincident rx_stb.
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:    if (armed)  state_nxt = S_CMD;
                S_CMD:     if (rx_stb) state_nxt = rx_byte[7] ? S_RD_REQ : S_WR;
                S_WR:      state_nxt = S_WR;
                S_RD_REQ:  state_nxt = S_RD_LOAD;
                S_RD_LOAD: state_nxt = S_RD_WAIT;
                S_RD_WAIT: if (rx_stb) state_nxt = S_RD_REQ;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs and datapath controls
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] addr;
    logic [7:0]        tx_data_q;
    logic              wr_fire;
    logic              err_set;
    logic              err_clr;
    logic              cmd_load;
    logic              addr_inc;

    always_comb begin
        reg_re   = 1'b0;
        tx_start = 1'b0;
        tx_data  = tx_data_q;
        wr_fire  = 1'b0;
        err_set  = 1'b0;
        err_clr  = 1'b0;
        cmd_load = 1'b0;
        addr_inc = 1'b0;
        if (!cs_s) begin
            unique case (state)
                S_IDLE: err_clr = armed;
                S_CMD:  cmd_load = rx_stb;
                S_WR: begin
                    if (rx_stb) begin
                        wr_fire  = in_range(addr);
                        err_set  = !in_range(addr);
                        addr_inc = 1'b1;
                    end
                end
                S_RD_REQ: begin
                    reg_re  = in_range(addr);
                    err_set = !in_range(addr);
                end
                S_RD_LOAD: begin
                    // Read data arrives this cycle; present it with the load
                    // pulse and keep it in tx_data_q afterwards.
                    tx_start = 1'b1;
                    tx_data  = in_range(addr) ? reg_rdata : 8'hFF;
                    addr_inc = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= '0;
            reg_addr  <= '0;
            reg_wdata <= 8'h00;
            reg_we    <= 1'b0;
            tx_data_q <= 8'h00;
            err       <= 1'b0;
        end else begin
            reg_we <= wr_fire;
            if (wr_fire) begin
                reg_addr  <= addr;
                reg_wdata <= rx_byte;
            end
            // Read address must be on the bus during RD_REQ, when reg_re is decoded.
            if (state_nxt == S_RD_REQ) begin
                reg_addr <= cmd_load ? rx_byte[ADDR_W-1:0] : addr;
            end
            if (cmd_load) begin
                addr <= rx_byte[ADDR_W-1:0];
            end else if (addr_inc) begin
                addr <= addr + ADDR_W'(1);
            end
            if (tx_start) begin
                tx_data_q <= tx_data;
            end
            if (err_clr) begin
                err <= 1'b0;
            end else if (err_set) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_reg_ctrl
//
// Directed bench for spi_reg_ctrl. Two instances share the same stimulus:
// index 0 has DEPTH=128, index 1 has DEPTH=16 (for out-of-range behaviour).
// Each instance has its own behavioural register bank (synchronous read, data
// valid the cycle after reg_re). A negedge monitor logs strobes with the
// cycle they appeared in; the stimulus sequence compares those logs against
// hand-computed values. rx_valid rises at a negedge when cyc == t; rx_stb is
// then seen at t+3, reg_we / reg_re at t+4 and tx_start at t+5.
// ---------------------------------------------------------------------------
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs;
    logic       rx_valid;
    logic [7:0] rx_data;

    logic [7:0] tx_data_v  [2];
    logic       tx_start_v [2];
    logic [6:0] addr_v     [2];
    logic [7:0] wdata_v    [2];
    logic       we_v       [2];
    logic       re_v       [2];
    logic [7:0] rdata_v    [2];
    logic       busy_v     [2];
    logic       err_v      [2];

    always #5 clk = ~clk;

    spi_reg_ctrl #(.ADDR_W(7), .DEPTH(128)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data_v[0]),
        .tx_start  (tx_start_v[0]),
        .reg_addr  (addr_v[0]),
        .reg_wdata (wdata_v[0]),
        .reg_we    (we_v[0]),
        .reg_re    (re_v[0]),
        .reg_rdata (rdata_v[0]),
        .busy      (busy_v[0]),
        .err       (err_v[0])
    );

    spi_reg_ctrl #(.ADDR_W(7), .DEPTH(16)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data_v[1]),
        .tx_start  (tx_start_v[1]),
        .reg_addr  (addr_v[1]),
        .reg_wdata (wdata_v[1]),
        .reg_we    (we_v[1]),
        .reg_re    (re_v[1]),
        .reg_rdata (rdata_v[1]),
        .busy      (busy_v[1]),
        .err       (err_v[1])
    );

    // Register banks, preloaded while reset is asserted.
    logic [7:0] bank [2][128];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 128; j++) bank[i][j] <= 8'h00;
                rdata_v[i] <= 8'h00;
            end
            bank[0][16] <= 8'h3C;
            bank[0][17] <= 8'hC3;
            bank[1][15] <= 8'h5A;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (we_v[i]) bank[i][addr_v[i]] <= wdata_v[i];
                if (re_v[i]) rdata_v[i] <= bank[i][addr_v[i]];
            end
        end
    end

    // Cycle counter and strobe monitor.
    int         cyc = 0;
    int         we_cnt [2] = '{0, 0};
    int         we_cyc [2] = '{0, 0};
    int         re_cnt [2] = '{0, 0};
    int         re_cyc [2] = '{0, 0};
    int         ts_cnt [2] = '{0, 0};
    int         ts_cyc [2] = '{0, 0};
    logic [6:0] we_addr[2];
    logic [7:0] we_data[2];
    logic [7:0] ts_data[2];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (we_v[i]) begin
                we_cnt[i]  = we_cnt[i] + 1;
                we_cyc[i]  = cyc;
                we_addr[i] = addr_v[i];
                we_data[i] = wdata_v[i];
            end
            if (re_v[i]) begin
                re_cnt[i] = re_cnt[i] + 1;
                re_cyc[i] = cyc;
            end
            if (tx_start_v[i]) begin
                ts_cnt[i]  = ts_cnt[i] + 1;
                ts_cyc[i]  = cyc;
                ts_data[i] = tx_data_v[i];
            end
        end
    end

    // Checking and stimulus helpers.
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cs_low();
        cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        cs = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Called at a negedge; t0 is the cycle count at which rx_valid rose.
    task automatic send_byte(input logic [7:0] b, output int t0);
        rx_data  = b;
        rx_valid = 1'b1;
        t0       = cyc;
        repeat (6) @(negedge clk);
        rx_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    int t;
    int na, nb, ra, rb, sa, sb;

    initial begin
        rst      = 1'b1;
        cs       = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_tx_data",   tx_data_v[0],  8'h00);
        check("rst_tx_start",  tx_start_v[0], 1'b0);
        check("rst_reg_addr",  addr_v[0],     7'h00);
        check("rst_reg_wdata", wdata_v[0],    8'h00);
        check("rst_reg_we",    we_v[0],       1'b0);
        check("rst_reg_re",    re_v[0],       1'b0);
        check("rst_busy",      busy_v[0],     1'b0);
        check("rst_err",       err_v[0],      1'b0);

        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Write burst: 0x05, 0xAA, 0xBB
        cs_low();
        check("wr_busy_on", busy_v[0], 1'b1);
        send_byte(8'h05, t);
        na = we_cnt[0];
        check("wr_cmd_no_we", we_cnt[0], 0);
        send_byte(8'hAA, t);
        check("wr1_cnt",  we_cnt[0], na + 1);
        check("wr1_cyc",  we_cyc[0], t + 4);
        check("wr1_addr", we_addr[0], 7'h05);
        check("wr1_data", we_data[0], 8'hAA);
        send_byte(8'hBB, t);
        check("wr2_cnt",  we_cnt[0], na + 2);
        check("wr2_cyc",  we_cyc[0], t + 4);
        check("wr2_addr", we_addr[0], 7'h06);
        check("wr2_data", we_data[0], 8'hBB);
        check("wr_err",   err_v[0], 1'b0);
        cs_high();
        check("wr_busy_off", busy_v[0], 1'b0);

        // Read burst at 0x10
        cs_low();
        sa = ts_cnt[0];
        send_byte(8'h90, t);
        check("rd1_re_cyc", re_cyc[0], t + 4);
        check("rd1_ts_cnt", ts_cnt[0], sa + 1);
        check("rd1_ts_cyc", ts_cyc[0], t + 5);
        check("rd1_data",   ts_data[0], 8'h3C);
        send_byte(8'h00, t);
        check("rd2_ts_cnt", ts_cnt[0], sa + 2);
        check("rd2_ts_cyc", ts_cyc[0], t + 5);
        check("rd2_data",   ts_data[0], 8'hC3);
        check("rd_err",     err_v[0], 1'b0);
        cs_high();

        // Out of range on the DEPTH=16 instance
        cs_low();
        nb = we_cnt[1];
        send_byte(8'h12, t);
        send_byte(8'h77, t);
        check("oor_wr_no_we", we_cnt[1], nb);
        check("oor_wr_err",   err_v[1], 1'b1);
        cs_high();
        check("oor_err_sticky", err_v[1], 1'b1);
        cs_low();
        check("oor_err_clr", err_v[1], 1'b0);
        send_byte(8'h8F, t);
        check("oor_rd1_data", ts_data[1], 8'h5A);
        check("oor_rd1_cyc",  ts_cyc[1], t + 5);
        check("oor_rd1_err",  err_v[1], 1'b0);
        rb = re_cnt[1];
        send_byte(8'h00, t);
        check("oor_rd2_data",  ts_data[1], 8'hFF);
        check("oor_rd2_cyc",   ts_cyc[1], t + 5);
        check("oor_rd2_no_re", re_cnt[1], rb);
        check("oor_rd2_err",   err_v[1], 1'b1);
        cs_high();
        cs_low();
        check("oor_new_frame_clr", err_v[1], 1'b0);
        cs_high();

        // Address wrap on the DEPTH=128 instance
        cs_low();
        send_byte(8'h7F, t);
        send_byte(8'h11, t);
        check("wrap1_addr", we_addr[0], 7'h7F);
        check("wrap1_data", we_data[0], 8'h11);
        send_byte(8'h22, t);
        check("wrap2_addr", we_addr[0], 7'h00);
        check("wrap2_data", we_data[0], 8'h22);
        cs_high();

        // Abort between command and data, then a normal frame
        cs_low();
        na = we_cnt[0];
        send_byte(8'h03, t);
        cs_high();
        check("abort_no_we", we_cnt[0], na);
        check("abort_busy",  busy_v[0], 1'b0);
        send_byte(8'h55, t);
        check("idle_stb_ignored", we_cnt[0], na);
        cs_low();
        send_byte(8'h20, t);
        send_byte(8'h44, t);
        check("post_abort_cnt",  we_cnt[0], na + 1);
        check("post_abort_addr", we_addr[0], 7'h20);
        check("post_abort_data", we_data[0], 8'h44);
        cs_high();

        // Asynchronous reset in the middle of a read burst
        cs_low();
        send_byte(8'h90, t);
        check("mid_tx_hold", tx_data_v[0], 8'h3C);
        check("mid_err_b",   err_v[1], 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_tx_data",   tx_data_v[0], 8'h00);
        check("arst_tx_start",  tx_start_v[0], 1'b0);
        check("arst_reg_addr",  addr_v[0], 7'h00);
        check("arst_reg_wdata", wdata_v[0], 8'h00);
        check("arst_reg_we",    we_v[0], 1'b0);
        check("arst_reg_re",    re_v[0], 1'b0);
        check("arst_busy",      busy_v[0], 1'b0);
        check("arst_err_b",     err_v[1], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        na = we_cnt[0];
        ra = re_cnt[0];
        sa = ts_cnt[0];
        nb = we_cnt[1];
        send_byte(8'h81, t);
        check("stray_no_we", we_cnt[0], na);
        check("stray_no_re", re_cnt[0], ra);
        check("stray_no_ts", ts_cnt[0], sa);
        check("stray_no_we_b", we_cnt[1], nb);
        cs_high();
        cs_low();
        send_byte(8'h30, t);
        send_byte(8'h66, t);
        check("recover_cnt",  we_cnt[0], na + 1);
        check("recover_addr", we_addr[0], 7'h30);
        check("recover_data", we_data[0], 8'h66);
        cs_high();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Command controller that sits behind the SPI slave byte interface and turns a chip-select framed byte stream into register-bank reads and writes. It decodes a command byte (R/W + address), auto-increments the address for burst transfers, and drives the slave's `tx_data`/`tx_start` for read data. It runs in the system clock domain and synchronizes the slave's SPI-domain `cs` and `data_valid` signals internally.

## Interface

Parameters:
- `ADDR_W`, 7: register address width; the command byte carries the address in bits [6:0].
- `DEPTH`, 128: number of implemented registers; valid addresses are 0..DEPTH-1, with DEPTH ≤ 2^ADDR_W.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `cs`  in  1  SPI chip select, active low, asynchronous to `clk`
- `rx_data`  in  8  received byte from the SPI slave; stable while `rx_valid` is high
- `rx_valid`  in  1  byte-received flag from the SPI slave, asynchronous; held high for ≥1 sclk period
- `tx_data`  out  8  byte the SPI slave returns on the next transfer
- `tx_start`  out  1  1-cycle pulse: `tx_data` is valid and must be loaded
- `reg_addr`  out  ADDR_W  register bank address
- `reg_wdata`  out  8  register write data
- `reg_we`  out  1  1-cycle write strobe
- `reg_re`  out  1  1-cycle read strobe
- `reg_rdata`  in  8  register read data, valid the cycle after `reg_re`
- `busy`  out  1  high while a frame is active (synced `cs` low)
- `err`  out  1  sticky: an out-of-range access occurred in the current or last frame

## Operation

- Synchronization:
  - `cs` passes through a 2-flop synchronizer to give `cs_s`.
  - `rx_valid` passes through a 2-flop synchronizer; a rising-edge detector on its output gives a 1-cycle `rx_stb`.
  - `rx_data` is sampled on `rx_stb`.
- FSM states: IDLE, CMD, WR, RD_REQ, RD_LOAD, RD_WAIT.
  - IDLE: on `cs_s` falling, clear `err` and go to CMD.
  - CMD: on `rx_stb`, latch `addr = rx_data[ADDR_W-1:0]`.
    - If `rx_data[7]=0`, go to WR.
    - If `rx_data[7]=1`, go to RD_REQ.
  - WR: on `rx_stb`:
    - If `addr < DEPTH`: `reg_we=1`, `reg_wdata=rx_data`, `reg_addr=addr`.
    - Otherwise: no strobe; set `err`.
    - Then `addr <= addr+1` (mod 2^ADDR_W). Stay in WR.
  - RD_REQ: `reg_re=1` and `reg_addr=addr` if in range; otherwise no strobe and set `err`. Go to RD_LOAD.
  - RD_LOAD: `tx_data <= reg_rdata` (or 8'hFF if out of range); pulse `tx_start`; `addr <= addr+1`. Go to RD_WAIT.
  - RD_WAIT: on `rx_stb` (the master has clocked out the byte; received byte ignored), go to RD_REQ.
- Burst example: a read command at address A returns A, A+1, … on successive bytes. The first read byte is prefetched immediately after the command byte.
- `cs_s` high in any state goes to IDLE next cycle. Any in-flight strobe is suppressed and `addr` is not updated.
- `rx_stb` while in IDLE is ignored.

## Timing

- Reset values: `tx_data=8'h00`, `tx_start=0`, `reg_addr=0`, `reg_wdata=0`, `reg_we=0`, `reg_re=0`, `busy=0`, `err=0`. FSM in IDLE; synchronizer flops at 1 for `cs` and 0 for `rx_valid`.
- `rx_valid` rising to `rx_stb`: 3 clk cycles (2 sync + edge detect).
- Write latency: `reg_we` is asserted in the cycle after `rx_stb`.
- Read latency:
  - Command `rx_stb` (cycle N) → `reg_re` at N+1 → `tx_start`/`tx_data` at N+2.
  - The same N+2 timing applies after each RD_WAIT `rx_stb`.
- Clock ratio: `clk` must be ≥ 4× sclk, so the next byte is loaded before the master's next byte starts.
- Address wrap: 2^ADDR_W-1 → 0.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous); a frame still in progress after reset release is ignored until `cs` deasserts and reasserts.
- `busy` = `cs_s` inverted, registered (1 cycle after `cs_s`).
- Simultaneous `rx_stb` and `cs_s` rising: deselect wins; no strobe is issued.

## Test plan

- Write burst: cs low, bytes 0x05, 0xAA, 0xBB → `reg_we` at addr 5 with 0xAA, then addr 6 with 0xBB; each strobe 1 cycle after `rx_stb`; `err=0`.
- Read burst: bank[0x10]=0x3C, bank[0x11]=0xC3; bytes 0x90, dummy, dummy → `tx_start` with 0x3C 2 cycles after the command `rx_stb`, then 0xC3 2 cycles after the next `rx_stb`.
- Out of range with DEPTH=16: write command 0x12 plus one data byte → no `reg_we`, `err=1`. A following read frame at address 0x0F → first byte from bank[0x0F], second byte 0xFF, `err=1`. A new frame clears `err` on cs fall.
- Address wrap with DEPTH=128: write 0x7F, 0x11, 0x22 → writes at addr 0x7F then 0x00.
- Abort: cs rises between command byte and data byte → FSM in IDLE, no `reg_we`. A subsequent write frame behaves normally.
- Asynchronous reset asserted mid read burst → all outputs 0 at once; a stray `rx_valid` before cs cycles produces no strobes.
